// File: rtl/sha2_round_ctrl_pkg.sv
// Shared SHA-2 definitions: round controller state encoding, block geometry and error codes.
package sha2_round_ctrl_pkg;

    localparam int NumRound  = 64;
    localparam int NumWordIn = 16;
    localparam int RoundW    = $clog2(NumRound);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StInit     = 3'd1,
        StCompress = 3'd2,
        StUpdate   = 3'd3,
        StDone     = 3'd4
    } sha2_round_st_e;

    typedef enum logic [31:0] {
        NoError                    = 32'h0000_0000,
        SwPushMsgWhenShaDisabled   = 32'h0000_0001,
        SwHashStartWhenShaDisabled = 32'h0000_0002,
        SwUpdateSecretKeyInProcess = 32'h0000_0003,
        SwHashStartWhenActive      = 32'h0000_0004,
        SwPushMsgWhenDisallowed    = 32'h0000_0005,
        ErrStartWhileBusy          = 32'h0000_0006
    } sha2_err_code_e;

endpackage

// File: rtl/sha2_round_ctrl.sv
// SHA-256 round sequencer: one compress round per cycle, update 1 cycle after round 63.
// Stalls only in rounds 0-15 while the word stream is not valid; ready never looks at valid.
module sha2_round_ctrl
    import sha2_round_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sha_en,
    input  logic              hash_start,
    input  logic              wipe_secret,
    input  logic              msg_feed_complete,
    input  logic              shaf_rvalid,
    output logic              shaf_rready,
    output logic [RoundW-1:0] round_o,
    output logic              w_load_o,
    output logic              w_calc_o,
    output logic              hash_init_o,
    output logic              round_en_o,
    output logic              hash_update_o,
    output logic              wipe_o,
    output logic              hash_done,
    output logic              busy_o,
    output logic              err_start_busy_o
);

    localparam logic [RoundW-1:0] LastLoadRound = RoundW'(NumWordIn - 1);
    localparam logic [RoundW-1:0] LastRound     = RoundW'(NumRound - 1);

    sha2_round_st_e    state;
    logic [RoundW-1:0] round;
    logic              busy;
    logic              active;
    logic              in_load;

    assign busy    = (state != StIdle);
    // A wipe or a dropped enable kills every datapath command in the same cycle.
    assign active  = sha_en && !wipe_secret;
    assign in_load = (round <= LastLoadRound);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= StIdle;
            round <= '0;
        end else if (wipe_secret) begin
            state <= StIdle;
            round <= '0;
        end else if (busy && !sha_en) begin
            state <= StIdle;
            round <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (sha_en && hash_start) begin
                        state <= StInit;
                    end
                end
                StInit: begin
                    round <= '0;
                    state <= StCompress;
                end
                StCompress: begin
                    if (in_load) begin
                        if (shaf_rvalid) begin
                            round <= round + RoundW'(1);
                        end else if (round == '0 && msg_feed_complete) begin
                            state <= StDone;
                        end
                    end else if (round == LastRound) begin
                        round <= '0;
                        state <= StUpdate;
                    end else begin
                        round <= round + RoundW'(1);
                    end
                end
                StUpdate: begin
                    round <= '0;
                    state <= StCompress;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    round <= '0;
                end
            endcase
        end
    end

    always_comb begin
        shaf_rready   = 1'b0;
        w_load_o      = 1'b0;
        w_calc_o      = 1'b0;
        hash_init_o   = 1'b0;
        round_en_o    = 1'b0;
        hash_update_o = 1'b0;
        hash_done     = 1'b0;
        case (state)
            StInit: begin
                hash_init_o = active;
            end
            StCompress: begin
                if (in_load) begin
                    shaf_rready = active;
                    w_load_o    = active && shaf_rvalid;
                    round_en_o  = active && shaf_rvalid;
                end else begin
                    w_calc_o   = active;
                    round_en_o = active;
                end
            end
            StUpdate: begin
                hash_update_o = active;
            end
            StDone: begin
                hash_done = active;
            end
            default: begin
                shaf_rready = 1'b0;
            end
        endcase
    end

    assign round_o          = round;
    assign wipe_o           = wipe_secret;
    assign busy_o           = busy;
    assign err_start_busy_o = busy && hash_start;

endmodule

// File: tb/tb_sha2_round_ctrl.sv
// Directed bench for sha2_round_ctrl: streams padded words with optional stalls and checks sequencing.
module tb_sha2_round_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       sha_en;
    logic       hash_start;
    logic       wipe_secret;
    logic       msg_feed_complete;
    logic       shaf_rvalid;
    logic       shaf_rready;
    logic [5:0] round_o;
    logic       w_load_o;
    logic       w_calc_o;
    logic       hash_init_o;
    logic       round_en_o;
    logic       hash_update_o;
    logic       wipe_o;
    logic       hash_done;
    logic       busy_o;
    logic       err_start_busy_o;

    sha2_round_ctrl dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .sha_en            (sha_en),
        .hash_start        (hash_start),
        .wipe_secret       (wipe_secret),
        .msg_feed_complete (msg_feed_complete),
        .shaf_rvalid       (shaf_rvalid),
        .shaf_rready       (shaf_rready),
        .round_o           (round_o),
        .w_load_o          (w_load_o),
        .w_calc_o          (w_calc_o),
        .hash_init_o       (hash_init_o),
        .round_en_o        (round_en_o),
        .hash_update_o     (hash_update_o),
        .wipe_o            (wipe_o),
        .hash_done         (hash_done),
        .busy_o            (busy_o),
        .err_start_busy_o  (err_start_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Stream source state
    bit feed_on;
    int total_words;
    int words_sent;
    int stall_left;
    int stall_tab[0:64];

    // Per-test observations
    int cyc_n = 0;
    int start_cyc, init_cyc, upd_cyc, prev_upd_cyc, done_cyc;
    int n_init, n_round_en, n_update, n_done, n_hs, n_wipe, n_err, n_wraps, n_stall_moves;
    logic [5:0] prev_round;
    bit prev_stall;

    task automatic clear_stats();
        n_init = 0; n_round_en = 0; n_update = 0; n_done = 0; n_hs = 0;
        n_wipe = 0; n_err = 0; n_wraps = 0; n_stall_moves = 0;
        init_cyc = -1; upd_cyc = -1; prev_upd_cyc = -1; done_cyc = -1;
        prev_round = '0; prev_stall = 1'b0;
        for (int i = 0; i <= 64; i++) stall_tab[i] = 0;
    endtask

    // One clock cycle: drive the stream, sample mid-cycle, then advance to just after the edge.
    task automatic cyc();
        if (feed_on && words_sent < total_words) shaf_rvalid = (stall_left == 0);
        else                                     shaf_rvalid = 1'b0;
        msg_feed_complete = feed_on && (words_sent == total_words);
        #2;
        if (hash_init_o)      begin n_init++; init_cyc = cyc_n; end
        if (round_en_o)       n_round_en++;
        if (hash_update_o)    begin n_update++; prev_upd_cyc = upd_cyc; upd_cyc = cyc_n; end
        if (hash_done)        begin n_done++; done_cyc = cyc_n; end
        if (wipe_o)           n_wipe++;
        if (err_start_busy_o) n_err++;
        if (prev_round == 6'd63 && round_o == 6'd0) n_wraps++;
        if (prev_stall && round_o != prev_round) n_stall_moves++;
        prev_stall = busy_o && shaf_rready && !shaf_rvalid;
        prev_round = round_o;
        if (shaf_rvalid && shaf_rready) begin
            n_hs++;
            words_sent++;
            stall_left = (words_sent <= 64) ? stall_tab[words_sent] : 0;
        end else if (shaf_rready && !shaf_rvalid && stall_left > 0) begin
            stall_left--;
        end
        cyc_n++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wait_round(input logic [5:0] r);
        for (int k = 0; k < 300 && round_o !== r; k++) cyc();
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400 && n_done == 0; k++) cyc();
        run_cycles(3);
    endtask

    task automatic start_block(input int nwords);
        feed_on     = 1'b1;
        total_words = nwords;
        words_sent  = 0;
        stall_left  = stall_tab[0];
        sha_en      = 1'b1;
        hash_start  = 1'b1;
        start_cyc   = cyc_n;
        cyc();
        hash_start  = 1'b0;
    endtask

    task automatic test_reset();
        clear_stats();
        feed_on = 1'b0; total_words = 0; words_sent = 0; stall_left = 0;
        rst_ni = 1'b0; sha_en = 1'b1; hash_start = 1'b0; wipe_secret = 1'b0;
        run_cycles(2);
        n_checks++;
        if ({shaf_rready, w_load_o, w_calc_o, hash_init_o, round_en_o, hash_update_o,
             wipe_o, hash_done, busy_o, err_start_busy_o} !== 10'b0)
            $display("FAIL reset_outputs: got %b want 0", {shaf_rready, w_load_o, w_calc_o,
                     hash_init_o, round_en_o, hash_update_o, wipe_o, hash_done, busy_o, err_start_busy_o});
        else n_pass++;
        n_checks++;
        if (round_o !== 6'd0) $display("FAIL reset_round: got %0d want 0", round_o);
        else n_pass++;
        rst_ni = 1'b1;
        // Start while disabled must be ignored silently.
        sha_en = 1'b0; hash_start = 1'b1;
        cyc();
        hash_start = 1'b0;
        run_cycles(2);
        n_checks++;
        if (busy_o !== 1'b0 || n_err != 0) $display("FAIL start_disabled: busy=%b err=%0d want 0/0", busy_o, n_err);
        else n_pass++;
    endtask

    task automatic test_one_block();
        clear_stats();
        start_block(16);
        wait_done();
        n_checks++;
        if (init_cyc - start_cyc != 1) $display("FAIL one_init_lat: got %0d want 1", init_cyc - start_cyc);
        else n_pass++;
        n_checks++;
        if (n_round_en != 64) $display("FAIL one_round_en: got %0d want 64", n_round_en);
        else n_pass++;
        n_checks++;
        if (upd_cyc - init_cyc != 65) $display("FAIL one_update_lat: got %0d want 65", upd_cyc - init_cyc);
        else n_pass++;
        n_checks++;
        if (n_done != 1 || done_cyc - upd_cyc != 2)
            $display("FAIL one_done: count=%0d gap=%0d want 1/2", n_done, done_cyc - upd_cyc);
        else n_pass++;
        n_checks++;
        if (n_hs != 16) $display("FAIL one_handshakes: got %0d want 16", n_hs);
        else n_pass++;
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL one_idle_after: busy=%b want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_stalled();
        clear_stats();
        stall_tab[0] = 3; stall_tab[7] = 3; stall_tab[15] = 3;
        start_block(16);
        wait_done();
        n_checks++;
        if (upd_cyc - init_cyc != 74) $display("FAIL stall_update_lat: got %0d want 74", upd_cyc - init_cyc);
        else n_pass++;
        n_checks++;
        if (n_round_en != 64) $display("FAIL stall_round_en: got %0d want 64", n_round_en);
        else n_pass++;
        n_checks++;
        if (n_stall_moves != 0) $display("FAIL stall_round_hold: moved %0d times want 0", n_stall_moves);
        else n_pass++;
        n_checks++;
        if (n_hs != 16 || n_done != 1) $display("FAIL stall_complete: hs=%0d done=%0d want 16/1", n_hs, n_done);
        else n_pass++;
    endtask

    task automatic test_two_blocks();
        clear_stats();
        start_block(32);
        wait_done();
        n_checks++;
        if (n_update != 2 || upd_cyc - prev_upd_cyc != 65)
            $display("FAIL two_updates: count=%0d gap=%0d want 2/65", n_update, upd_cyc - prev_upd_cyc);
        else n_pass++;
        n_checks++;
        if (n_done != 1) $display("FAIL two_done: got %0d want 1", n_done);
        else n_pass++;
        n_checks++;
        if (n_wraps != 2) $display("FAIL two_wraps: got %0d want 2", n_wraps);
        else n_pass++;
        n_checks++;
        if (n_hs != 32 || n_round_en != 128) $display("FAIL two_counts: hs=%0d rounds=%0d want 32/128", n_hs, n_round_en);
        else n_pass++;
    endtask

    task automatic test_abort_wipe();
        clear_stats();
        start_block(16);
        wait_round(6'd30);
        sha_en = 1'b0;
        cyc();
        n_checks++;
        if (busy_o !== 1'b0 || round_o !== 6'd0) $display("FAIL abort_idle: busy=%b round=%0d want 0/0", busy_o, round_o);
        else n_pass++;
        sha_en = 1'b1;
        run_cycles(80);
        n_checks++;
        if (n_done != 0 || n_update != 0) $display("FAIL abort_no_done: done=%0d upd=%0d want 0/0", n_done, n_update);
        else n_pass++;

        clear_stats();
        start_block(16);
        wait_round(6'd40);
        wipe_secret = 1'b1;
        #1;
        n_checks++;
        if (wipe_o !== 1'b1 || round_en_o !== 1'b0) $display("FAIL wipe_cycle: wipe=%b round_en=%b want 1/0", wipe_o, round_en_o);
        else n_pass++;
        cyc();
        wipe_secret = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || round_o !== 6'd0) $display("FAIL wipe_idle: busy=%b round=%0d want 0/0", busy_o, round_o);
        else n_pass++;
        run_cycles(80);
        n_checks++;
        if (n_wipe != 1 || n_done != 0) $display("FAIL wipe_once: wipes=%0d done=%0d want 1/0", n_wipe, n_done);
        else n_pass++;
    endtask

    task automatic test_busy_start();
        clear_stats();
        start_block(16);
        wait_round(6'd20);
        hash_start = 1'b1;
        #1;
        n_checks++;
        if (err_start_busy_o !== 1'b1) $display("FAIL busy_err_pulse: got %b want 1", err_start_busy_o);
        else n_pass++;
        cyc();
        hash_start = 1'b0;
        #1;
        n_checks++;
        if (err_start_busy_o !== 1'b0 || round_o !== 6'd21)
            $display("FAIL busy_after: err=%b round=%0d want 0/21", err_start_busy_o, round_o);
        else n_pass++;
        wait_done();
        n_checks++;
        if (n_init != 1 || n_err != 1 || n_round_en != 64 || n_done != 1)
            $display("FAIL busy_undisturbed: init=%0d err=%0d rounds=%0d done=%0d want 1/1/64/1",
                     n_init, n_err, n_round_en, n_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_stats();
        start_block(16);
        wait_round(6'd10);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b1 || round_o !== 6'd10) $display("FAIL rst_between_edges: busy=%b round=%0d want 1/10", busy_o, round_o);
        else n_pass++;
        cyc();
        rst_ni = 1'b1;
        feed_on = 1'b0;
        #1;
        n_checks++;
        if ({shaf_rready, w_load_o, w_calc_o, hash_init_o, round_en_o, hash_update_o,
             wipe_o, hash_done, busy_o, err_start_busy_o} !== 10'b0 || round_o !== 6'd0)
            $display("FAIL rst_mid_outputs: outs=%b round=%0d want 0/0", {shaf_rready, w_load_o, w_calc_o,
                     hash_init_o, round_en_o, hash_update_o, wipe_o, hash_done, busy_o, err_start_busy_o}, round_o);
        else n_pass++;
        run_cycles(5);
        n_checks++;
        if (n_done != 0 || n_update != 0) $display("FAIL rst_mid_no_done: done=%0d upd=%0d want 0/0", n_done, n_update);
        else n_pass++;
    endtask

    initial begin
        rst_ni = 1'b0; sha_en = 1'b0; hash_start = 1'b0; wipe_secret = 1'b0;
        msg_feed_complete = 1'b0; shaf_rvalid = 1'b0;
        feed_on = 1'b0; total_words = 0; words_sent = 0; stall_left = 0;
        @(posedge clk_i);
        #1;
        test_reset();
        test_one_block();
        test_stalled();
        test_two_blocks();
        test_abort_wipe();
        test_busy_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
